spw_tx_scheduler: RTL and testbench

//  Sequences the SpaceWire transmit encoder on behalf of the link FSM: picks one symbol per

---
 rtl/spw_tx_scheduler.sv | 223 ++++++++++++++++++++++
 tb/tb_spw_tx_scheduler.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spw_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : spw_tx_scheduler
// Description : SpaceWire transmit symbol scheduler. Picks TIMECODE/FCT/NCHAR/
//               NULL for each encoder slot and owns the tx and rx credit counters.
//               Define SPW_TIMECODE_EN to build in the time-code path.
// Revision    : 1.0 - initial release
// ============================================================================
module spw_tx_scheduler #(
    parameter int MAX_CREDIT = 56,
    parameter int FCT_STEP   = 8,
    parameter int CW         = 6
) (
    input  logic          pclk,
    input  logic          resetn,
    input  logic          enable_tx,
    input  logic          send_null_tx,
    input  logic          send_fct_tx,
    input  logic          link_run,
    input  logic          rx_got_fct,
    input  logic          rx_got_nchar,
    input  logic [CW-1:0] rx_fifo_free,
    input  logic          tx_write,
    input  logic [8:0]    tx_data,
    output logic          tx_ready,
    input  logic          tick_in,
    input  logic [7:0]    time_in,
    output logic          enc_valid,
    output logic [1:0]    enc_type,
    output logic [8:0]    enc_data,
    input  logic          enc_ready,
    output logic          credit_error,
    output logic          rx_overrun,
    output logic [CW-1:0] tx_credit
);

    localparam logic [0:0]    c_IDLE    = 1'b0;
    localparam logic [0:0]    c_OFFER   = 1'b1;
    localparam logic [1:0]    c_T_NULL  = 2'd0;
    localparam logic [1:0]    c_T_FCT   = 2'd1;
    localparam logic [1:0]    c_T_NCHAR = 2'd2;
    localparam logic [1:0]    c_T_TC    = 2'd3;
    localparam logic [CW:0]   c_MAX     = MAX_CREDIT[CW:0];
    localparam logic [CW:0]   c_STEP    = FCT_STEP[CW:0];
    localparam logic [CW-1:0] c_ONE     = 1;

    logic [0:0]    r_state;
    logic [0:0]    w_next_state;
    logic [1:0]    r_type;
    logic [8:0]    r_data;
    logic          r_hold_full;
    logic [8:0]    r_hold_data;
    logic [CW-1:0] r_tx_credit;
    logic [CW-1:0] r_rx_credit;
    logic          r_credit_error;
    logic          r_rx_overrun;

    logic          w_flush;
    logic          w_accept;
    logic          w_load;
    logic          w_sel_valid;
    logic [1:0]    w_sel_type;
    logic [8:0]    w_sel_data;
    logic          w_tc_elig;
    logic [8:0]    w_tc_data;
    logic [CW:0]   w_fct_sum;
    logic          w_fct_elig;
    logic          w_nchar_elig;
    logic [CW:0]   w_tx_sum;
    logic          w_tx_ovf;
    logic          w_tx_dec;
    logic [CW-1:0] w_tx_next;
    logic          w_rx_inc;
    logic          w_rx_ovr;
    logic [CW-1:0] w_rx_next;

    assign w_flush = ~resetn | ~enable_tx;

`ifdef SPW_TIMECODE_EN
    logic       r_tick_pend;
    logic [7:0] r_time;

    // A tick arriving in the same cycle as a TIMECODE accept re-arms pending.
    always_ff @(posedge pclk) begin
        if (w_flush) begin
            r_tick_pend <= 1'b0;
            r_time      <= 8'd0;
        end else begin
            if (w_accept && r_type == c_T_TC)
                r_tick_pend <= 1'b0;
            if (tick_in && link_run) begin
                r_tick_pend <= 1'b1;
                r_time      <= time_in;
            end
        end
    end

    assign w_tc_elig = link_run & r_tick_pend;
    assign w_tc_data = {1'b0, r_time};
`else
    logic w_unused_tick;
    assign w_unused_tick = ^{tick_in, time_in};
    assign w_tc_elig     = 1'b0;
    assign w_tc_data     = 9'd0;
`endif

    assign w_fct_sum    = {1'b0, r_rx_credit} + c_STEP;
    assign w_fct_elig   = send_fct_tx & (w_fct_sum <= c_MAX) & ({1'b0, rx_fifo_free} >= w_fct_sum);
    assign w_nchar_elig = link_run & r_hold_full & (r_tx_credit != '0);

    always_comb begin
        w_sel_valid = 1'b1;
        w_sel_type  = c_T_NULL;
        w_sel_data  = 9'd0;
        if (w_tc_elig) begin
            w_sel_type = c_T_TC;
            w_sel_data = w_tc_data;
        end else if (w_fct_elig) begin
            w_sel_type = c_T_FCT;
        end else if (w_nchar_elig) begin
            w_sel_type = c_T_NCHAR;
            w_sel_data = r_hold_data;
        end else if (!send_null_tx) begin
            w_sel_valid = 1'b0;
        end
    end

    always_ff @(posedge pclk) begin
        if (w_flush)
            r_state <= c_IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (w_sel_valid) w_next_state = c_OFFER;
            c_OFFER: if (enc_ready)   w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    always_comb begin
        enc_valid = (r_state == c_OFFER);
        w_accept  = (r_state == c_OFFER) & enc_ready;
        w_load    = (r_state == c_IDLE) & w_sel_valid;
    end

    always_ff @(posedge pclk) begin
        if (w_flush) begin
            r_type <= c_T_NULL;
            r_data <= 9'd0;
        end else if (w_load) begin
            r_type <= w_sel_type;
            r_data <= w_sel_data;
        end else if (w_accept) begin
            r_type <= c_T_NULL;
            r_data <= 9'd0;
        end
    end

    assign enc_type = r_type;
    assign enc_data = r_data;

    assign tx_ready = enable_tx & link_run & ~r_hold_full & (r_tx_credit != '0);

    always_ff @(posedge pclk) begin
        if (w_flush) begin
            r_hold_full <= 1'b0;
            r_hold_data <= 9'd0;
        end else if (tx_write && tx_ready) begin
            r_hold_full <= 1'b1;
            r_hold_data <= tx_data;
        end else if (w_tx_dec) begin
            r_hold_full <= 1'b0;
        end
    end

    // An overflowing FCT is dropped but a simultaneous N-char send still consumes credit.
    assign w_tx_sum = {1'b0, r_tx_credit} + c_STEP;
    assign w_tx_ovf = rx_got_fct & (w_tx_sum > c_MAX);
    assign w_tx_dec = w_accept & (r_type == c_T_NCHAR);

    always_comb begin
        w_tx_next = r_tx_credit;
        if (rx_got_fct && !w_tx_ovf)
            w_tx_next = w_tx_sum[CW-1:0];
        if (w_tx_dec)
            w_tx_next = w_tx_next - c_ONE;
    end

    assign w_rx_inc = w_accept & (r_type == c_T_FCT);
    assign w_rx_ovr = rx_got_nchar & (r_rx_credit == '0);

    always_comb begin
        w_rx_next = r_rx_credit;
        if (w_rx_inc)
            w_rx_next = w_fct_sum[CW-1:0];
        if (rx_got_nchar && !w_rx_ovr)
            w_rx_next = w_rx_next - c_ONE;
    end

    always_ff @(posedge pclk) begin
        if (w_flush) begin
            r_tx_credit    <= '0;
            r_rx_credit    <= '0;
            r_credit_error <= 1'b0;
            r_rx_overrun   <= 1'b0;
        end else begin
            r_tx_credit    <= w_tx_next;
            r_rx_credit    <= w_rx_next;
            r_credit_error <= w_tx_ovf;
            r_rx_overrun   <= w_rx_ovr;
        end
    end

    assign tx_credit    = r_tx_credit;
    assign credit_error = r_credit_error;
    assign rx_overrun   = r_rx_overrun;

endmodule
`default_nettype wire

// File: tb/tb_spw_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_spw_tx_scheduler
// Description : Directed plus randomized bench for spw_tx_scheduler against a
//               cycle-level reference model built from the link rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spw_tx_scheduler;

    localparam int MAXC = 56;
    localparam int STEP = 8;
    localparam int CW   = 6;
`ifdef SPW_TIMECODE_EN
    localparam bit TC_EN = 1'b1;
`else
    localparam bit TC_EN = 1'b0;
`endif

    logic          pclk = 1'b0;
    logic          resetn = 1'b0;
    logic          enable_tx = 1'b0;
    logic          send_null_tx = 1'b0;
    logic          send_fct_tx = 1'b0;
    logic          link_run = 1'b0;
    logic          rx_got_fct = 1'b0;
    logic          rx_got_nchar = 1'b0;
    logic [CW-1:0] rx_fifo_free = '0;
    logic          tx_write = 1'b0;
    logic [8:0]    tx_data = 9'd0;
    logic          tx_ready;
    logic          tick_in = 1'b0;
    logic [7:0]    time_in = 8'd0;
    logic          enc_valid;
    logic [1:0]    enc_type;
    logic [8:0]    enc_data;
    logic          enc_ready = 1'b0;
    logic          credit_error;
    logic          rx_overrun;
    logic [CW-1:0] tx_credit;

    int errors = 0;
    int checks = 0;

    // Reference model: symbol on offer, credits, holding queue, pending tick
    bit m_off;
    int m_type, m_data, m_txc, m_rxc, m_tval;
    bit m_tpend, m_cerr, m_ovr, m_wr_acc;
    int m_hold[$];

    int n_sym[4];
    int n_cerr, n_ovr;

    spw_tx_scheduler dut (
        .pclk         (pclk),
        .resetn       (resetn),
        .enable_tx    (enable_tx),
        .send_null_tx (send_null_tx),
        .send_fct_tx  (send_fct_tx),
        .link_run     (link_run),
        .rx_got_fct   (rx_got_fct),
        .rx_got_nchar (rx_got_nchar),
        .rx_fifo_free (rx_fifo_free),
        .tx_write     (tx_write),
        .tx_data      (tx_data),
        .tx_ready     (tx_ready),
        .tick_in      (tick_in),
        .time_in      (time_in),
        .enc_valid    (enc_valid),
        .enc_type     (enc_type),
        .enc_data     (enc_data),
        .enc_ready    (enc_ready),
        .credit_error (credit_error),
        .rx_overrun   (rx_overrun),
        .tx_credit    (tx_credit)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_ready();
        return enable_tx && link_run && (m_hold.size() == 0) && (m_txc > 0);
    endfunction

    task automatic clear_counts();
        for (int i = 0; i < 4; i++) n_sym[i] = 0;
        n_cerr = 0;
        n_ovr  = 0;
    endtask

    // One clock: check outputs mid-cycle, advance the model, return after the edge.
    task automatic cycle();
        bit acc, rdy;
        int t, r;
        @(negedge pclk);
        check("enc_valid", enc_valid, m_off);
        check("enc_type", enc_type, m_type);
        check("enc_data", enc_data, m_data);
        check("tx_ready", tx_ready, exp_ready());
        check("tx_credit", tx_credit, m_txc);
        check("credit_error", credit_error, m_cerr);
        check("rx_overrun", rx_overrun, m_ovr);
        if (enc_valid === 1'b1 && enc_ready) n_sym[enc_type]++;
        if (credit_error === 1'b1) n_cerr++;
        if (rx_overrun === 1'b1) n_ovr++;

        m_wr_acc = 1'b0;
        if (!resetn || !enable_tx) begin
            m_off = 0; m_type = 0; m_data = 0; m_txc = 0; m_rxc = 0;
            m_tpend = 0; m_tval = 0; m_cerr = 0; m_ovr = 0;
            m_hold.delete();
        end else begin
            acc = m_off && enc_ready;
            rdy = exp_ready();
            t = m_txc;
            r = m_rxc;
            m_cerr = 0;
            m_ovr  = 0;
            if (rx_got_fct) begin
                if (t + STEP > MAXC) m_cerr = 1;
                else t += STEP;
            end
            if (acc && m_type == 2) t -= 1;
            if (acc && m_type == 1) r += STEP;
            if (rx_got_nchar) begin
                if (m_rxc == 0) m_ovr = 1;
                else r -= 1;
            end
            if (m_off) begin
                if (acc) begin
                    if (m_type == 2) void'(m_hold.pop_front());
                    if (m_type == 3) m_tpend = 0;
                    m_off = 0; m_type = 0; m_data = 0;
                end
            end else if (TC_EN && link_run && m_tpend) begin
                m_off = 1; m_type = 3; m_data = m_tval;
            end else if (send_fct_tx && m_rxc + STEP <= MAXC && int'(rx_fifo_free) >= m_rxc + STEP) begin
                m_off = 1; m_type = 1; m_data = 0;
            end else if (link_run && m_hold.size() > 0 && m_txc > 0) begin
                m_off = 1; m_type = 2; m_data = m_hold[0];
            end else if (send_null_tx) begin
                m_off = 1; m_type = 0; m_data = 0;
            end
            if (tx_write && rdy) begin
                m_hold.push_back(int'(tx_data));
                m_wr_acc = 1'b1;
            end
            if (TC_EN && tick_in && link_run) begin
                m_tpend = 1;
                m_tval  = int'(time_in);
            end
            m_txc = t;
            m_rxc = r;
        end
        @(posedge pclk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nwr, k;
        m_off = 0; m_type = 0; m_data = 0; m_txc = 0; m_rxc = 0;
        m_tpend = 0; m_tval = 0; m_cerr = 0; m_ovr = 0;
        clear_counts();

        // Reset
        run(3);
        resetn = 1'b1;
        run(2);
        check("reset_valid", enc_valid, 0);
        check("reset_credit", tx_credit, 0);

        // NULLs only: one transfer every other cycle
        enable_tx = 1; send_null_tx = 1; enc_ready = 1;
        clear_counts();
        run(20);
        check("null_count", n_sym[0], 10);
        check("null_only_other", n_sym[1] + n_sym[2] + n_sym[3], 0);
        check("null_credit", tx_credit, 0);

        // FCT flow: exactly seven FCTs fill rx credit, then NULLs resume
        send_fct_tx = 1; rx_fifo_free = 6'(MAXC);
        clear_counts();
        run(40);
        check("fct_count", n_sym[1], 7);
        check("fct_then_null", n_sym[0], 13);

        // One FCT received grants eight N-chars; the ninth write stalls
        link_run = 1;
        rx_got_fct = 1; run(1); rx_got_fct = 0; run(1);
        check("credit_after_fct", tx_credit, 8);
        clear_counts();
        nwr = 0;
        tx_write = 1;
        for (int i = 0; i < 80; i++) begin
            tx_data = (nwr == 7) ? 9'h100 : 9'(8'h30 + nwr);
            cycle();
            if (m_wr_acc) nwr++;
        end
        tx_write = 0;
        run(2);
        check("nchar_writes", nwr, 8);
        check("nchar_sent", n_sym[2], 8);
        check("nchar_ready_low", tx_ready, 0);
        check("nchar_credit", tx_credit, 0);

        // Credit ceiling and overflow
        clear_counts();
        repeat (7) begin
            rx_got_fct = 1; run(1); rx_got_fct = 0; run(1);
        end
        check("credit_full", tx_credit, MAXC);
        rx_got_fct = 1; run(1); rx_got_fct = 0; run(2);
        check("credit_error_pulses", n_cerr, 1);
        check("credit_hold", tx_credit, MAXC);

        // Time-code outranks a simultaneously eligible FCT and N-char
        enc_ready = 0;
        run(3);
        rx_got_nchar = 1; run(8); rx_got_nchar = 0;
        tx_write = 1; tx_data = 9'h055; run(1); tx_write = 0;
        tick_in = 1; time_in = 8'h2A; run(1); tick_in = 0;
        clear_counts();
        enc_ready = 1;
        run(2);
        check("prio_valid", enc_valid, 1);
        check("prio_type", enc_type, TC_EN ? 3 : 1);
        check("prio_data", enc_data, TC_EN ? 9'h02A : 9'h000);
        run(20);
        check("prio_tc_sent", n_sym[3], TC_EN ? 1 : 0);
        check("prio_fct_sent", n_sym[1], 1);
        check("prio_nchar_sent", n_sym[2], 1);

        // RX overrun once receive credit is exhausted
        send_fct_tx = 0;
        clear_counts();
        k = m_rxc;
        rx_got_nchar = 1; run(64); rx_got_nchar = 0; run(2);
        check("overrun_pulses", n_ovr, 64 - k);

        // Link drop while an offer is outstanding
        enc_ready = 0;
        for (int i = 0; i < 10 && !m_off; i++) cycle();
        check("drop_offer_seen", enc_valid, 1);
        enable_tx = 0;
        run(1);
        check("drop_valid", enc_valid, 0);
        check("drop_credit", tx_credit, 0);
        check("drop_ready", tx_ready, 0);
        enable_tx = 1;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            enable_tx    = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 49) == 0) link_run = ~link_run;
            send_null_tx = ($urandom_range(0, 9) != 0);
            send_fct_tx  = ($urandom_range(0, 3) != 0);
            rx_fifo_free = 6'($urandom_range(0, MAXC));
            rx_got_fct   = (m_txc + STEP <= MAXC) && ($urandom_range(0, 7) == 0);
            rx_got_nchar = (m_rxc > 0) && ($urandom_range(0, 3) == 0);
            tx_write     = 1'($urandom_range(0, 1));
            tx_data      = 9'($urandom);
            tick_in      = !m_tpend && !(m_off && m_type == 3) && ($urandom_range(0, 19) == 0);
            time_in      = 8'($urandom);
            enc_ready    = ($urandom_range(0, 2) != 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
